// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one combinational signed multiplier between two
// requesters, with per-requester response slots and a programmable settle time.
`timescale 1ns/1ps
module mul_share_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MUL_LAT = 1      // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_result,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_result,

    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_result,

    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             owner;
    logic             last;
    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic             done;

    // A full response slot blocks its requester, even if it drains this cycle.
    assign elig0 = req0_valid & ~rsp0_valid;
    assign elig1 = req1_valid & ~rsp1_valid;

    // Next-state, grant and completion decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant0    = 1'b0;
        grant1    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                grant0 = elig0 & (~elig1 | last);
                grant1 = elig1 & (~elig0 | ~last);
                if (grant0 | grant1) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(MUL_LAT);
                end
            end
            BUSY: begin
                if (cnt > CNT_W'(1)) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
            done   = 1'b0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operand capture, arbitration history and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            owner    <= 1'b0;
            last     <= 1'b1;
            busy     <= 1'b0;
            op_count <= '0;
        end else begin
            busy <= (state_nxt == BUSY);
            if (grant0) begin
                mul_a <= req0_a;
                mul_b <= req0_b;
                owner <= 1'b0;
                last  <= 1'b0;
            end else if (grant1) begin
                mul_a <= req1_a;
                mul_b <= req1_b;
                owner <= 1'b1;
                last  <= 1'b1;
            end
            if (done) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

    // Response slots: a capture never meets a drain of the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
        end else begin
            if (done && !owner) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= mul_result;
            end else if (rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end
            if (done && owner) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= mul_result;
            end else if (rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end
        end
    end

endmodule
